// File: rtl/zip_dbg_master_if.sv
// Wishbone-style debug bus between zip_dbg_master and the ZipCPU debug slave.
// addr 0 selects the control/status word, addr 1 the register data word.
interface zip_dbg_master_if;
  logic        cyc;
  logic        stb;
  logic        we;
  logic        addr;
  logic [31:0] wdata;
  logic        ack;
  logic        stall;
  logic [31:0] rdata;

  modport master (
    output cyc, stb, we, addr, wdata,
    input  ack, stall, rdata
  );

  modport slave (
    input  cyc, stb, we, addr, wdata,
    output ack, stall, rdata
  );
endinterface

// File: rtl/zip_dbg_master.sv
// Host-command sequencer for the ZipCPU debug slave: turns each command into
// a control access and/or a data access and returns one response per command.
module zip_dbg_master #(
  parameter bit OPT_ADDR_CACHE = 1'b1,
  parameter int LGTIMEOUT      = 10
) (
  input  logic        i_clk,
  input  logic        i_rst,
  // Command channel: a command is taken when i_cmd_stb && !o_cmd_busy; the
  // response is a single o_rsp_stb pulse, and o_cmd_busy falls the cycle after.
  input  logic        i_cmd_stb,
  input  logic [1:0]  i_cmd_op,
  input  logic [4:0]  i_cmd_reg,
  input  logic [31:0] i_cmd_data,
  output logic        o_cmd_busy,
  output logic        o_rsp_stb,
  output logic [31:0] o_rsp_data,
  output logic        o_rsp_err,
  output logic [2:0]  o_state,
  zip_dbg_master_if.master dbg
);

  localparam logic [1:0] OP_RDREG  = 2'b00;
  localparam logic [1:0] OP_WRREG  = 2'b01;
  localparam logic [1:0] OP_CTRL   = 2'b10;
  localparam logic [1:0] OP_STATUS = 2'b11;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_CREQ = 3'd1;
  localparam logic [2:0] S_CACK = 3'd2;
  localparam logic [2:0] S_DREQ = 3'd3;
  localparam logic [2:0] S_DACK = 3'd4;
  localparam logic [2:0] S_RESP = 3'd5;

  logic [2:0]           r_state;
  logic [1:0]           r_op;
  logic [4:0]           r_reg;
  logic [31:0]          r_data;
  logic [LGTIMEOUT-1:0] r_tmo;
  logic                 r_cache_vld;
  logic [4:0]           r_cache_reg;
  logic                 r_we;
  logic                 r_addr;
  logic [31:0]          r_wdata;
  logic                 r_rsp_stb;
  logic [31:0]          r_rsp_data;
  logic                 r_rsp_err;

  logic [LGTIMEOUT-1:0] w_tmo_next;
  logic                 w_timeout;
  logic                 w_abort;
  logic                 w_rdwr_in;
  logic                 w_hit;
  logic                 w_rdwr;
  logic [31:0]          w_ctl_word;

  assign w_tmo_next = r_tmo + {{(LGTIMEOUT-1){1'b0}}, 1'b1};
  assign w_timeout  = &w_tmo_next;
  // A request waiting on stall, or an access waiting on ack, gives up when
  // the counter is about to reach all-ones.
  assign w_abort    = w_timeout &&
                      ((((r_state == S_CREQ) || (r_state == S_DREQ)) && dbg.stall) ||
                       (((r_state == S_CACK) || (r_state == S_DACK)) && !dbg.ack));
  assign w_rdwr_in  = !i_cmd_op[1];
  assign w_rdwr     = !r_op[1];
  assign w_hit      = OPT_ADDR_CACHE && r_cache_vld && (r_cache_reg == i_cmd_reg) && w_rdwr_in;
  assign w_ctl_word = 32'h0000_0400 | {27'd0, i_cmd_reg};

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_op        <= 2'b00;
      r_reg       <= 5'd0;
      r_data      <= 32'd0;
      r_tmo       <= '0;
      r_cache_vld <= 1'b0;
      r_cache_reg <= 5'd0;
      r_we        <= 1'b0;
      r_addr      <= 1'b0;
      r_wdata     <= 32'd0;
      r_rsp_stb   <= 1'b0;
      r_rsp_data  <= 32'd0;
      r_rsp_err   <= 1'b0;
    end else begin
      r_rsp_stb <= 1'b0;
      if (w_abort) begin
        r_state     <= S_RESP;
        r_rsp_stb   <= 1'b1;
        r_rsp_data  <= 32'd0;
        r_rsp_err   <= 1'b1;
        r_cache_vld <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (i_cmd_stb) begin
              r_op   <= i_cmd_op;
              r_reg  <= i_cmd_reg;
              r_data <= i_cmd_data;
              r_tmo  <= '0;
              if (i_cmd_op == OP_CTRL)
                r_cache_vld <= 1'b0;
              if (w_hit) begin
                r_state <= S_DREQ;
                r_we    <= (i_cmd_op == OP_WRREG);
                r_addr  <= 1'b1;
                r_wdata <= (i_cmd_op == OP_WRREG) ? i_cmd_data : 32'd0;
              end else begin
                r_state <= S_CREQ;
                r_we    <= (i_cmd_op != OP_STATUS);
                r_addr  <= 1'b0;
                r_wdata <= w_rdwr_in ? w_ctl_word :
                           ((i_cmd_op == OP_CTRL) ? i_cmd_data : 32'd0);
              end
            end
          end
          S_CREQ, S_DREQ: begin
            r_tmo <= w_tmo_next;
            if (!dbg.stall)
              r_state <= (r_state == S_CREQ) ? S_CACK : S_DACK;
          end
          S_CACK: begin
            if (dbg.ack) begin
              if (w_rdwr) begin
                // Control word landed: remember it so a repeat can go straight to data.
                r_cache_vld <= OPT_ADDR_CACHE;
                r_cache_reg <= r_reg;
                r_state     <= S_DREQ;
                r_tmo       <= '0;
                r_we        <= (r_op == OP_WRREG);
                r_addr      <= 1'b1;
                r_wdata     <= (r_op == OP_WRREG) ? r_data : 32'd0;
              end else begin
                r_state    <= S_RESP;
                r_rsp_stb  <= 1'b1;
                r_rsp_data <= (r_op == OP_STATUS) ? dbg.rdata : 32'd0;
                r_rsp_err  <= 1'b0;
              end
            end else begin
              r_tmo <= w_tmo_next;
            end
          end
          S_DACK: begin
            if (dbg.ack) begin
              r_state    <= S_RESP;
              r_rsp_stb  <= 1'b1;
              r_rsp_data <= (r_op == OP_RDREG) ? dbg.rdata : 32'd0;
              r_rsp_err  <= 1'b0;
            end else begin
              r_tmo <= w_tmo_next;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign dbg.cyc    = (r_state == S_CREQ) || (r_state == S_CACK) ||
                      (r_state == S_DREQ) || (r_state == S_DACK);
  assign dbg.stb    = (r_state == S_CREQ) || (r_state == S_DREQ);
  assign dbg.we     = r_we;
  assign dbg.addr   = r_addr;
  assign dbg.wdata  = r_wdata;
  assign o_cmd_busy = (r_state != S_IDLE);
  assign o_rsp_stb  = r_rsp_stb;
  assign o_rsp_data = r_rsp_data;
  assign o_rsp_err  = r_rsp_err;
  assign o_state    = r_state;

endmodule

// File: tb/tb_zip_dbg_master.sv
// Directed bench for zip_dbg_master: command-level model predicts bus accesses,
// response timing/content and busy/cyc windows; a negedge process compares.
module tb_zip_dbg_master;
  localparam int LG = 5;
  localparam bit OPT = 1'b1;

  localparam logic [1:0] RD = 2'b00, WR = 2'b01, CT = 2'b10, ST = 2'b11;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_stb;
  logic [1:0]  cmd_op;
  logic [4:0]  cmd_reg;
  logic [31:0] cmd_data;
  logic        busy, rsp_stb, rsp_err;
  logic [31:0] rsp_data;
  logic [2:0]  state;

  zip_dbg_master_if dbg();

  zip_dbg_master #(.OPT_ADDR_CACHE(OPT), .LGTIMEOUT(LG)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_cmd_stb(cmd_stb), .i_cmd_op(cmd_op), .i_cmd_reg(cmd_reg), .i_cmd_data(cmd_data),
    .o_cmd_busy(busy), .o_rsp_stb(rsp_stb), .o_rsp_data(rsp_data), .o_rsp_err(rsp_err),
    .o_state(state), .dbg(dbg)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  int cyc_n = 0;
  always @(posedge clk) cyc_n++;

  int n_chk = 0, n_pass = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc_n);
  endtask

  // model state and scoreboards
  bit          m_vld = 1'b0;
  logic [4:0]  m_reg = 5'd0;
  int          m_acc_cyc = 0, m_cyc_end = 0, m_busy_end = 0;
  logic [31:0] exp_q[$];
  bit          exp_err_q[$];
  int          exp_cyc_q[$];
  logic [33:0] acc_q[$];
  bit          acc_chk_q[$];

  // responder controls / observations
  bit          started = 1'b0;
  bit          ack_en = 1'b1;
  int          stall_budget = 0;
  logic [31:0] resp_word = 32'd0;
  bit          pend_ack = 1'b0;
  int          ctl_wr_cnt = 0, stb_run = 0, last_stb_run = 0;
  int          rsp_cnt = 0, last_rsp_cyc = 0;
  logic [31:0] last_rsp_data;
  bit          last_rsp_err;
  bit          prev_hold = 1'b0;
  logic        prev_we, prev_addr;
  logic [31:0] prev_data;

  // responder + compare process
  always @(negedge clk) begin
    logic [33:0] a;
    bit          c;
    if (started) begin
      if (rsp_stb) begin
        rsp_cnt++;
        last_rsp_cyc  = cyc_n;
        last_rsp_data = rsp_data;
        last_rsp_err  = rsp_err;
        if (exp_q.size() == 0) begin
          n_chk++;
          $display("FAIL rsp_unexpected: got rsp data %h at cycle %0d, required none", rsp_data, cyc_n);
        end else begin
          chk("rsp_data", rsp_data, exp_q.pop_front());
          chk("rsp_err", 32'(rsp_err), 32'(exp_err_q.pop_front()));
          chk("rsp_cycle", cyc_n, exp_cyc_q.pop_front());
        end
      end
      chk("busy", 32'(busy), 32'((cyc_n > m_acc_cyc) && (cyc_n <= m_busy_end)));
      chk("dbg_cyc", 32'(dbg.cyc), 32'((cyc_n > m_acc_cyc) && (cyc_n <= m_cyc_end)));
      if (prev_hold) begin
        chk("stall_stb", 32'(dbg.stb), 32'd1);
        chk("stall_we", 32'(dbg.we), 32'(prev_we));
        chk("stall_addr", 32'(dbg.addr), 32'(prev_addr));
        chk("stall_data", dbg.wdata, prev_data);
      end
    end
    dbg.ack   = pend_ack && ack_en;
    dbg.rdata = resp_word;
    pend_ack  = 1'b0;
    if (dbg.stb && dbg.addr && stall_budget > 0) begin
      dbg.stall = 1'b1;
      stall_budget--;
    end else begin
      dbg.stall = 1'b0;
    end
    if (dbg.stb && !dbg.stall) begin
      pend_ack = 1'b1;
      last_stb_run = stb_run + 1;
      stb_run = 0;
      if (dbg.we && !dbg.addr) ctl_wr_cnt++;
      if (acc_q.size() == 0) begin
        n_chk++;
        $display("FAIL acc_unexpected: got we=%b addr=%b data=%h, required none", dbg.we, dbg.addr, dbg.wdata);
      end else begin
        a = acc_q.pop_front();
        c = acc_chk_q.pop_front();
        chk("acc_we", 32'(dbg.we), 32'(a[33]));
        chk("acc_addr", 32'(dbg.addr), 32'(a[32]));
        if (c) chk("acc_data", dbg.wdata, a[31:0]);
      end
    end else if (dbg.stb) begin
      stb_run++;
    end
    prev_hold = dbg.stb && dbg.stall;
    prev_we   = dbg.we;
    prev_addr = dbg.addr;
    prev_data = dbg.wdata;
  end

  // driver: predicts the command's effects, drives it, waits for its outcome
  task automatic issue(input logic [1:0] op, input logic [4:0] rg, input logic [31:0] d,
                       input int dstall, input bit acken, input int rst_at, input bit pulse,
                       output int lat);
    int n, c0, k, exp_lat;
    bit hit, rdwr;
    k = 0;
    while (busy && k < 50) begin @(negedge clk); k++; end
    if (busy) begin n_chk++; $display("FAIL idle_wait: busy still %b, required 0", busy); end
    n    = cyc_n;
    c0   = rsp_cnt;
    rdwr = !op[1];
    hit  = OPT && rdwr && m_vld && (m_reg == rg);
    if (rdwr) begin
      if (!hit) begin acc_q.push_back({1'b1, 1'b0, 32'h400 | {27'd0, rg}}); acc_chk_q.push_back(1'b1); end
      if (acken || hit) begin acc_q.push_back({op == WR, 1'b1, d}); acc_chk_q.push_back(op == WR); end
    end else begin
      acc_q.push_back({op == CT, 1'b0, d});
      acc_chk_q.push_back(op == CT);
    end
    if (op == CT) m_vld = 1'b0;
    if (!acken) begin
      exp_lat = 1 << LG;
      m_vld   = 1'b0;
    end else begin
      exp_lat = ((!rdwr || hit) ? 3 : 5) + dstall;
      if (rdwr) begin m_vld = OPT; m_reg = rg; end
    end
    if (rst_at > 0) begin
      m_vld = 1'b0;
      m_cyc_end = n + rst_at;
      m_busy_end = n + rst_at;
    end else begin
      exp_q.push_back((acken && (op == RD || op == ST)) ? resp_word : 32'd0);
      exp_err_q.push_back(!acken);
      exp_cyc_q.push_back(n + exp_lat);
      m_cyc_end = n + exp_lat - 1;
      m_busy_end = n + exp_lat;
    end
    m_acc_cyc    = n;
    stall_budget = dstall;
    ack_en       = acken;
    cmd_stb = 1'b1; cmd_op = op; cmd_reg = rg; cmd_data = d;
    @(negedge clk);
    cmd_stb = 1'b0;
    lat = -1;
    if (rst_at > 0) begin
      while (cyc_n < n + rst_at) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("rst_cyc", 32'(dbg.cyc), 32'd0);
      chk("rst_stb", 32'(dbg.stb), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      repeat (6) @(negedge clk);
      chk("rst_no_rsp", rsp_cnt, c0);
    end else begin
      for (k = 0; k < 100; k++) begin
        if (rsp_cnt != c0) break;
        @(negedge clk);
        if (pulse && cyc_n == n + 2) begin
          cmd_stb = 1'b1; cmd_op = CT; cmd_data = 32'd0;
        end else begin
          cmd_stb = 1'b0;
        end
      end
      cmd_stb = 1'b0;
      if (rsp_cnt == c0) begin
        n_chk++;
        $display("FAIL rsp_wait: no response within 100 cycles, required one");
      end else begin
        lat = last_rsp_cyc - n;
      end
    end
  endtask

  initial begin
    int lat, c0, w0;
    rst = 1'b1; cmd_stb = 1'b0; cmd_op = 2'b00; cmd_reg = 5'd0; cmd_data = 32'd0;
    dbg.ack = 1'b0; dbg.stall = 1'b0; dbg.rdata = 32'd0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("reset_cyc", 32'(dbg.cyc), 32'd0);
    chk("reset_stb", 32'(dbg.stb), 32'd0);
    chk("reset_we", 32'(dbg.we), 32'd0);
    chk("reset_wdata", dbg.wdata, 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_rsp", 32'(rsp_stb), 32'd0);
    chk("reset_state", 32'(state), 32'd0);
    started = 1'b1;
    @(negedge clk);

    // 1: cache-miss register read
    resp_word = 32'hDEAD0003;
    w0 = ctl_wr_cnt;
    issue(RD, 5'd3, 32'd0, 0, 1'b1, 0, 1'b0, lat);
    chk("t1_lat", lat, 5);
    chk("t1_data", last_rsp_data, 32'hDEAD0003);
    chk("t1_err", 32'(last_rsp_err), 32'd0);
    chk("t1_ctl_writes", ctl_wr_cnt - w0, 1);

    // 2: cache hit, then raw CTRL invalidates
    w0 = ctl_wr_cnt;
    issue(RD, 5'd3, 32'd0, 0, 1'b1, 0, 1'b0, lat);
    chk("t2_hit_lat", lat, 3);
    chk("t2_hit_ctl_writes", ctl_wr_cnt - w0, 0);
    issue(CT, 5'd0, 32'h0, 0, 1'b1, 0, 1'b0, lat);
    chk("t2_ctrl_lat", lat, 3);
    issue(RD, 5'd3, 32'd0, 0, 1'b1, 0, 1'b0, lat);
    chk("t2_after_ctrl_lat", lat, 5);

    // 3: register write with a stalled data strobe
    issue(WR, 5'd7, 32'h12345678, 3, 1'b1, 0, 1'b0, lat);
    chk("t3_lat", lat, 8);
    chk("t3_stb_cycles", last_stb_run, 4);
    chk("t3_data", last_rsp_data, 32'd0);
    chk("t3_err", 32'(last_rsp_err), 32'd0);

    // STATUS read leaves the cache alone
    resp_word = 32'h0000_0401;
    issue(ST, 5'd0, 32'd0, 0, 1'b1, 0, 1'b0, lat);
    chk("status_data", last_rsp_data, 32'h0000_0401);
    resp_word = 32'hA5A5_0007;
    issue(RD, 5'd7, 32'd0, 0, 1'b1, 0, 1'b0, lat);
    chk("status_keeps_cache_lat", lat, 3);

    // 4: STATUS never acked times out and invalidates the cache
    issue(ST, 5'd0, 32'd0, 0, 1'b0, 0, 1'b0, lat);
    ack_en = 1'b1;
    chk("t4_lat", lat, 32);
    chk("t4_err", 32'(last_rsp_err), 32'd1);
    chk("t4_data", last_rsp_data, 32'd0);
    issue(RD, 5'd7, 32'd0, 0, 1'b1, 0, 1'b0, lat);
    chk("t4_rewrite_lat", lat, 5);

    // 5: reset during the data ack wait of a read
    resp_word = 32'h0000_5555;
    issue(RD, 5'd5, 32'd0, 0, 1'b1, 4, 1'b0, lat);
    w0 = ctl_wr_cnt;
    issue(RD, 5'd5, 32'd0, 0, 1'b1, 0, 1'b0, lat);
    chk("t5_after_rst_lat", lat, 5);
    chk("t5_after_rst_ctl_writes", ctl_wr_cnt - w0, 1);

    // 6: a command strobe while busy is dropped
    c0 = rsp_cnt;
    issue(RD, 5'd5, 32'd0, 0, 1'b1, 0, 1'b1, lat);
    repeat (8) @(negedge clk);
    chk("t6_one_rsp", rsp_cnt - c0, 1);
    issue(RD, 5'd5, 32'd0, 0, 1'b1, 0, 1'b0, lat);
    chk("t6_cache_kept_lat", lat, 3);

    repeat (4) @(negedge clk);
    chk("exp_rsp_left", exp_q.size(), 0);
    chk("exp_acc_left", acc_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
